// File: rtl/am2922_scan_pkg.sv
// Shared types and sizes for the am2922 condition-mux scan controller.
package am2922_scan_pkg;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Pin group driven onto the am2922 (select, polarity, active-low enables)
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             pol;
    logic             re_;
    logic             me_;
    logic             oe_;
  } mux_drv_t;

  localparam mux_drv_t DRV_OFF = '{sel: '0, pol: 1'b0, re_: 1'b1, me_: 1'b1, oe_: 1'b1};

endpackage

// File: rtl/am2922_nextch.sv
// Finds the lowest set mask bit strictly above ch (or from bit 0 when first=1).
module am2922_nextch
  import am2922_scan_pkg::*;
(
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] ch,
  input  logic             first,
  output logic             found_c,
  output logic [SEL_W-1:0] next_ch_c
);

  // Descending walk so the lowest qualifying bit is the last one written
  always_comb begin
    found_c   = 1'b0;
    next_ch_c = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(ch)))) begin
        found_c   = 1'b1;
        next_ch_c = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/am2922_scan.sv
// Scan controller for one am2922: walks enabled channels, samples Y into status,
// and hands the result to the host with a done/ack handshake.
module am2922_scan
  import am2922_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       clr_,
  input  logic       start,
  input  logic       abort,
  input  logic       single,
  input  logic [2:0] sel,
  input  logic [7:0] mask,
  input  logic [7:0] polmask,
  input  logic       ack,
  output logic       busy,
  output logic       done,
  output logic [7:0] status,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       pol,
  output logic       re_,
  output logic       me_,
  output logic       oe_,
  input  logic       y
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  state_e           state_q, state_d;
  logic             armed_q, armed_d;
  logic [N_CH-1:0]  emask_q, emask_d;
  logic [N_CH-1:0]  pmask_q, pmask_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  status_q, status_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  mux_drv_t         drv_q, drv_d;

  logic             nxt_found_c;
  logic [SEL_W-1:0] nxt_ch_c;
  logic             go_load, go_done, go_abort;

  // One finder serves the first lookup (from IDLE) and every later step
  am2922_nextch u_nextch (
    .mask      (emask_q),
    .ch        (ch_q),
    .first     (state_q == ST_IDLE),
    .found_c   (nxt_found_c),
    .next_ch_c (nxt_ch_c)
  );

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state_q  <= ST_IDLE;
      armed_q  <= 1'b0;
      emask_q  <= '0;
      pmask_q  <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      status_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drv_q    <= DRV_OFF;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      emask_q  <= emask_d;
      pmask_q  <= pmask_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      drv_q    <= drv_d;
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    emask_d  = emask_q;
    pmask_d  = pmask_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    busy_d   = busy_q;
    done_d   = done_q;
    drv_d    = drv_q;
    go_load  = 1'b0;
    go_done  = 1'b0;
    go_abort = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A start is latched first; the channel decision follows one cycle later
        if (armed_q) begin
          armed_d = 1'b0;
          if (nxt_found_c) go_load = 1'b1;
          else             go_done = 1'b1;
        end else if (start) begin
          armed_d  = 1'b1;
          emask_d  = single ? (N_CH'(1) << sel) : mask;
          pmask_d  = polmask;
          status_d = '0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          go_abort = 1'b1;
        end else begin
          state_d  = ST_WAIT;
          cnt_d    = '0;
          drv_d.re_ = 1'b1;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          go_abort = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          status_d[ch_q] = y;
          if (nxt_found_c) go_load = 1'b1;
          else             go_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (ack) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_load) begin
      state_d   = ST_LOAD;
      ch_d      = nxt_ch_c;
      busy_d    = 1'b1;
      drv_d.sel = nxt_ch_c;
      drv_d.pol = pmask_q[nxt_ch_c];
      drv_d.re_ = 1'b0;
      drv_d.me_ = 1'b0;
      drv_d.oe_ = 1'b0;
    end

    // Select and polarity keep their last values once the scan ends
    if (go_done) begin
      state_d   = ST_DONE;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      drv_d.re_ = 1'b1;
      drv_d.me_ = 1'b1;
      drv_d.oe_ = 1'b1;
    end

    if (go_abort) begin
      state_d   = ST_IDLE;
      status_d  = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      drv_d.re_ = 1'b1;
      drv_d.me_ = 1'b1;
      drv_d.oe_ = 1'b1;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign status    = status_q;
  assign {c, b, a} = drv_q.sel;
  assign pol       = drv_q.pol;
  assign re_       = drv_q.re_;
  assign me_       = drv_q.me_;
  assign oe_       = drv_q.oe_;

endmodule
